// File: rtl/kgv_pkg.sv
// Shared types and constants for the kgV (least common multiple) calculator.
package kgv_pkg;

  localparam int unsigned KGV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } kgv_state_t;

endpackage

// File: rtl/kgv_div.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles after start.
module kgv_div
  import kgv_pkg::*;
#(
  parameter int unsigned WIDTH = KGV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] div_r;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // q_r shifts the dividend out at the top while quotient bits enter at the bottom.
  assign trial     = {rem_r, q_r[WIDTH-1]};
  assign diff      = trial - {1'b0, div_r};
  assign done      = running && (cnt == CW'(WIDTH - 1));
  assign quotient  = q_r;
  assign remainder = rem_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= '0;
      rem_r   <= '0;
      div_r   <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      q_r     <= dividend;
      rem_r   <= '0;
      div_r   <= divisor;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (!diff[WIDTH]) begin
        rem_r <= diff[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= trial[WIDTH-1:0];
        q_r   <= {q_r[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/kgv_rechner.sv
// kgV(a,b) = (a / ggT) * b with fixed 2*WIDTH+1 cycle latency.
// Optional macro KGV_CHECK_EN flags a nonzero division remainder as an error.
module kgv_rechner
  import kgv_pkg::*;
#(
  parameter int unsigned WIDTH = KGV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   zahl1_i,
  input  logic [WIDTH-1:0]   zahl2_i,
  input  logic [WIDTH-1:0]   ggt_i,
  output logic [2*WIDTH-1:0] kgv_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               fehler_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  kgv_state_t         state, state_n;
  logic               valid_q;
  logic               valid_rst;
  logic               capture;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic               ggt_zero;
  logic               chk_err;
  logic               div_done;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_rem;

  // valid_rst remembers a level held across reset release so it is not seen as a new edge.
  assign capture = (state == IDLE) && valid_i && !valid_q && !valid_rst;

  // The divider runs even when ggT = 0 so the latency stays fixed; its result is then discarded.
  kgv_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (capture),
    .dividend  (zahl1_i),
    .divisor   (ggt_i),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_rem)
  );

`ifdef KGV_CHECK_EN
  assign chk_err = |div_rem;
`else
  logic rem_unused;
  assign rem_unused = ^div_rem;
  assign chk_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (capture) state_n = DIV;
      DIV:     if (div_done) state_n = MUL;
      MUL:     if (cnt == CW'(WIDTH - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kgv_o     <= '0;
      fehler_o  <= 1'b0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      valid_q   <= 1'b0;
      valid_rst <= valid_i;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      ggt_zero  <= 1'b0;
    end else begin
      valid_q   <= valid_i;
      valid_rst <= 1'b0;
      valid_o   <= 1'b0;
      if (valid_o) busy_o <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            mcand    <= (2*WIDTH)'(zahl2_i);
            acc      <= '0;
            cnt      <= '0;
            ggt_zero <= (ggt_i == '0);
            busy_o   <= 1'b1;
          end
        end
        MUL: begin
          if (div_q[cnt] && !ggt_zero) acc <= acc + mcand;
          mcand <= mcand << 1;
          cnt   <= cnt + 1'b1;
        end
        DONE: begin
          valid_o  <= 1'b1;
          kgv_o    <= (ggt_zero || chk_err) ? '0 : acc;
          fehler_o <= ggt_zero || chk_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kgv_rechner.sv
// Directed self-checking bench for kgv_rechner (WIDTH = 16).
module tb_kgv_rechner;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [15:0] zahl1_i;
  logic [15:0] zahl2_i;
  logic [15:0] ggt_i;
  logic [31:0] kgv_o;
  logic        valid_o;
  logic        busy_o;
  logic        fehler_o;

  int total = 0;
  int bad   = 0;

  kgv_rechner #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .zahl1_i  (zahl1_i),
    .zahl2_i  (zahl2_i),
    .ggt_i    (ggt_i),
    .kgv_o    (kgv_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o),
    .fehler_o (fehler_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 100) begin
      step();
      lat++;
    end
  endtask

  // Starts a job, holds valid_i for 'hold' edges from the capture edge, checks result and aftermath.
  task automatic run_job(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                         input logic [31:0] ek, input logic ef, input int hold, input string tag);
    int lat;
    int t;
    int extra;
    zahl1_i = a; zahl2_i = b; ggt_i = g; valid_i = 1'b1;
    step();
    t = 1;
    if (t >= hold) valid_i = 1'b0;
    chk({tag, "_busy_cap"}, busy_o, 1);
    lat = 0;
    while (!valid_o && lat < 100) begin
      step();
      lat++; t++;
      if (t >= hold) valid_i = 1'b0;
    end
    chk({tag, "_lat"}, lat, 33);
    chk({tag, "_kgv"}, kgv_o, ek);
    chk({tag, "_fehler"}, fehler_o, ef);
    chk({tag, "_busy_valid"}, busy_o, 1);
    extra = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      t++;
      if (t >= hold) valid_i = 1'b0;
      if (valid_o) extra++;
      if (k == 0) chk({tag, "_busy_after"}, busy_o, 0);
    end
    chk({tag, "_extra_pulses"}, extra, 0);
    chk({tag, "_kgv_hold"}, kgv_o, ek);
  endtask

  initial begin
    int lat;
    int pulses;
    rst = 1'b1; valid_i = 1'b1;
    zahl1_i = 16'd12; zahl2_i = 16'd18; ggt_i = 16'd6;

    // Reset with valid_i held high across release: no job may start.
    repeat (3) step();
    chk("rst_kgv", kgv_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_fehler", fehler_o, 0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) pulses++;
    end
    chk("held_thru_rst_pulses", pulses, 0);
    chk("held_thru_rst_busy", busy_o, 0);
    valid_i = 1'b0;
    repeat (2) step();

    run_job(16'd24255, 16'd12540, 16'd165, 32'd1843380, 1'b0, 1, "basic");
    run_job(16'd12, 16'd18, 16'd6, 32'd36, 1'b0, 40, "held40");
    run_job(16'd65535, 16'd65534, 16'd1, 32'd4294770690, 1'b0, 1, "max");
    run_job(16'd0, 16'd0, 16'd0, 32'd0, 1'b1, 1, "ggt_zero");
    run_job(16'd0, 16'd7, 16'd7, 32'd0, 1'b0, 1, "a_zero");
    run_job(16'd5, 16'd0, 16'd5, 32'd0, 1'b0, 1, "b_zero");
    run_job(16'd100, 16'd100, 16'd100, 32'd100, 1'b0, 2, "equal");
`ifdef KGV_CHECK_EN
    run_job(16'd10, 16'd4, 16'd3, 32'd0, 1'b1, 1, "rem_chk");
`else
    run_job(16'd10, 16'd4, 16'd3, 32'd12, 1'b0, 1, "rem_nochk");
`endif

    // Reset at capture+10 aborts the job; a following job still works.
    zahl1_i = 16'd12; zahl2_i = 16'd18; ggt_i = 16'd6; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_kgv", kgv_o, 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    run_job(16'd8, 16'd12, 16'd4, 32'd24, 1'b0, 1, "after_abort");

    // Second edge at capture+5 is ignored.
    zahl1_i = 16'd12; zahl2_i = 16'd18; ggt_i = 16'd6; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (4) step();
    zahl1_i = 16'd9; zahl2_i = 16'd6; ggt_i = 16'd3; valid_i = 1'b1;
    wait_valid(lat);
    chk("busy_edge_lat", lat + 4, 33);
    chk("busy_edge_kgv", kgv_o, 36);
    valid_i = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) pulses++;
    end
    chk("busy_edge_pulses", pulses, 0);

    // Edge in the DONE cycle is ignored.
    zahl1_i = 16'd15; zahl2_i = 16'd10; ggt_i = 16'd5; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (32) step();
    chk("done_edge_pre_valid", valid_o, 0);
    zahl1_i = 16'd7; zahl2_i = 16'd3; ggt_i = 16'd1; valid_i = 1'b1;
    step();
    chk("done_edge_valid", valid_o, 1);
    chk("done_edge_kgv", kgv_o, 30);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (valid_o) pulses++;
    end
    chk("done_edge_pulses", pulses, 0);
    chk("done_edge_busy", busy_o, 0);
    valid_i = 1'b0;
    repeat (2) step();

    // Edge in the first IDLE cycle after DONE is accepted.
    zahl1_i = 16'd15; zahl2_i = 16'd10; ggt_i = 16'd5; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    wait_valid(lat);
    chk("idle_edge_lat1", lat, 33);
    chk("idle_edge_kgv1", kgv_o, 30);
    zahl1_i = 16'd7; zahl2_i = 16'd3; ggt_i = 16'd1; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("idle_edge_busy", busy_o, 1);
    wait_valid(lat);
    chk("idle_edge_lat2", lat, 33);
    chk("idle_edge_kgv2", kgv_o, 21);
    chk("idle_edge_fehler2", fehler_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kgv_rechner.md
KGV_RECHNER -- requirements
Module: kgv_rechner

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and ggT width; result width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port valid_i  input  1  ggT-valid from the upstream ggT core; may be held high for several cycles.
REQ-005 SHALL have port zahl1_i  input  WIDTH  operand a, the same value fed to the ggT core.
REQ-006 SHALL have port zahl2_i  input  WIDTH  operand b, the same value fed to the ggT core.
REQ-007 SHALL have port ggt_i  input  WIDTH  ggT(a,b) from the upstream ggT core.
REQ-008 SHALL have port kgv_o  output  2*WIDTH  kgV(a,b) result, registered.
REQ-009 SHALL have port valid_o  output  1  one-cycle pulse, kgv_o/fehler_o valid.
REQ-010 SHALL have port busy_o  output  1  high from capture until the cycle valid_o is asserted, inclusive.
REQ-011 SHALL have port fehler_o  output  1  error flag, registered, qualified by valid_o.

Function
REQ-012 SHALL capture zahl1_i, zahl2_i and ggt_i only on a valid_i rising edge (high now, low in previous cycle) while in IDLE.
REQ-013 SHALL ignore valid_i edges outside IDLE; no queueing.
REQ-014 SHALL use FSM states IDLE -> DIV -> MUL -> DONE -> IDLE.
REQ-015 DIV: restoring division q = a / ggt, exactly WIDTH cycles, one quotient bit per cycle, MSB first.
REQ-016 MUL: shift-add product q * b into a 2*WIDTH accumulator, exactly WIDTH cycles, LSB of q first.
REQ-017 DONE: load kgv_o/fehler_o, assert valid_o for exactly one cycle, then return to IDLE.
REQ-018 Latency SHALL be fixed: valid_o high exactly 2*WIDTH+1 cycles after the capture edge (33 for WIDTH=16).
REQ-019 kgv_o and fehler_o SHALL hold their value until the next DONE or reset.
REQ-020 If captured ggt = 0, SHALL skip arithmetic, still obey REQ-018 latency, output kgv_o = 0 and fehler_o = 1.
REQ-021 If a = 0 or b = 0 with ggt != 0, SHALL output kgv_o = 0 and fehler_o = 0.
REQ-022 The product SHALL never overflow: q*b <= (2^WIDTH-1)^2 fits in 2*WIDTH bits.
REQ-023 A valid_i rising edge in the same cycle as DONE SHALL be ignored.
REQ-024 A valid_i edge arriving in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-025 rst SHALL force IDLE and clear kgv_o = 0, valid_o = 0, busy_o = 0, fehler_o = 0, and the edge-detect register.
REQ-026 rst asserted mid-DIV/MUL SHALL abort without producing valid_o.
REQ-027 valid_i held high through reset release SHALL not count as a rising edge.

Configuration
REQ-028 Macro KGV_CHECK_EN, when defined, SHALL compile in a remainder check: a nonzero division remainder sets fehler_o = 1 and kgv_o = 0.
REQ-029 Without KGV_CHECK_EN, the remainder SHALL be discarded, kgv_o = q*b regardless, and fehler_o SHALL be set only under REQ-020.

Structure
REQ-030 Package kgv_pkg SHALL hold the FSM state enum typedef, the default WIDTH constant and the state encodings.
REQ-031 The restoring divider SHALL be the sub-module kgv_div (start, done, quotient, remainder); the multiplier stays inline.

Verification
REQ-032 a=24255, b=12540, ggt=165 -> kgv_o=1843380, fehler_o=0, valid_o at capture+33.
REQ-033 a=12, b=18, ggt=6 -> kgv_o=36; valid_i held high for 40 cycles -> exactly one valid_o pulse.
REQ-034 a=65535, b=65534, ggt=1 -> kgv_o=4294770690, fehler_o=0.
REQ-035 a=0, b=0, ggt=0 -> kgv_o=0, fehler_o=1, latency 33; a=10, b=4, ggt=3 with KGV_CHECK_EN -> kgv_o=0, fehler_o=1.
REQ-036 rst pulse at capture+10, then a new edge with a=8, b=12, ggt=4 -> no valid_o for the first job; second job gives kgv_o=24.
REQ-037 A second valid_i edge at capture+5 is ignored -> result matches the first operands only.
